prio_enc_rr: RTL

- Parametrised, registered N-to-log2(N) encoder with enable and an `active` flag.
- Selectable arbitration mode: fixed highest-index priority, or round-robin with a rotating priority pointer.
- Result is registered and presented through a valid/ready output handshake, so it can sit between a request bus and a downstream consumer that may stall.
- Successor to the combinational 8x3 encoder; at N=8 in fixed mode it matches that encoder's mapping, delayed by one cycle.

---
 rtl/prio_enc_rr.sv | 80 ++++++++
 1 files changed

// File: rtl/prio_enc_rr.sv
// Registered N-to-log2(N) priority encoder with fixed or round-robin arbitration.
// The result is held behind a valid/ready handshake so a stalled consumer never loses a grant.
module prio_enc_rr #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] s,
    input  logic         mode,
    output logic [W-1:0] y,
    output logic         active,
    output logic         y_valid,
    input  logic         y_ready
);

    if (N < 2 || (N & (N - 1)) != 0 || W != $clog2(N)) begin : g_bad_params
        $error("prio_enc_rr: N must be a power of two >= 2 and W must equal log2(N)");
    end

    logic [W-1:0] y_q;
    logic         active_q;
    logic         y_valid_q;
    logic [W-1:0] ptr_q;

    logic         cap;
    logic [N-1:0] s_rot;
    logic [W-1:0] fix_idx;
    logic [W-1:0] rot_idx;
    logic [W-1:0] rr_idx;
    logic [W-1:0] win;

    assign cap = !y_valid_q || y_ready;

    // NOTE: every always_comb output gets a default first, so no path through the block infers a latch.
    always_comb begin
        fix_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (s[i]) fix_idx = W'(i);
        end

        // Rotate so index ptr lands at bit 0; the lowest set bit is then the first in scan order.
        s_rot   = N'({s, s} >> ptr_q);
        rot_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (s_rot[i]) rot_idx = W'(i);
        end
        // Un-rotate; W-bit addition wraps modulo N because N is a power of two.
        rr_idx = rot_idx + ptr_q;

        win = mode ? rr_idx : fix_idx;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q       <= '0;
            active_q  <= 1'b0;
            y_valid_q <= 1'b0;
            ptr_q     <= '0;
        end else if (cap) begin
            if (en) begin
                y_valid_q <= 1'b1;
                active_q  <= |s;
                y_q       <= (|s) ? win : '0;
                if (mode && (|s)) ptr_q <= win + W'(1);
            end else begin
                y_valid_q <= 1'b0;
                active_q  <= 1'b0;
                y_q       <= '0;
            end
        end
    end

    assign y       = y_q;
    assign active  = active_q;
    assign y_valid = y_valid_q;

endmodule
